// File: rtl/mdu_pkg.sv
// Shared constants, funct codes and state encoding for the multiply/divide sequencer.
package mdu_pkg;

    localparam int XLEN      = 32;
    localparam int CNT_W     = 5;
    localparam int DIV_STEPS = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } mdu_state_t;

    function automatic logic is_mdu_funct(input logic [5:0] f);
        case (f)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO,
            F_MULT, F_MULTU, F_DIV, F_DIVU: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring divider on unsigned magnitudes: one quotient bit per cycle for 32 cycles.
module div_iter
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem,
    output logic            last
);

    logic [XLEN-1:0]  r_q;
    logic [XLEN-1:0]  r_r;
    logic [XLEN-1:0]  r_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_trial;

    // Partial remainder is always < divisor, so the 33-bit trial's top bit is a clean borrow.
    assign w_shift = {r_r, r_q[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_d};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_r    <= '0;
            r_d    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (abort) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start) begin
            r_q    <= dividend;
            r_r    <= '0;
            r_d    <= divisor;
            r_cnt  <= CNT_W'(DIV_STEPS - 1);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_q <= {r_q[XLEN-2:0], ~w_trial[XLEN]};
            if (!w_trial[XLEN]) begin
                r_r <= w_trial[XLEN-1:0];
            end else begin
                r_r <= w_shift[XLEN-1:0];
            end
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign quot = r_q;
    assign rem  = r_r;
    assign last = r_busy && (r_cnt == '0);

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; stalls EX while an operation is in flight.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mdu_valid,
    input  logic [5:0]      mdu_funct,
    input  logic [XLEN-1:0] mdu_a,
    input  logic [XLEN-1:0] mdu_b,
    input  logic            flush,
    output logic            mdu_stall,
    output logic [XLEN-1:0] mdu_rdata,
    output logic            mdu_done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    mdu_state_t         r_state;
    mdu_state_t         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [XLEN-1:0]    r_hi;
    logic [XLEN-1:0]    r_lo;
    logic [XLEN-1:0]    w_hi_next;
    logic [XLEN-1:0]    w_lo_next;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_signed;

    logic               w_accept;
    logic               w_accept_mul;
    logic               w_accept_div;
    logic               w_op_signed;
    logic [2*XLEN-1:0]  w_ext_a;
    logic [2*XLEN-1:0]  w_ext_b;
    logic [2*XLEN-1:0]  w_prod;
    logic [2*XLEN-1:0]  w_prod_out;

    logic [XLEN-1:0]    w_div_dividend;
    logic [XLEN-1:0]    w_div_divisor;
    logic [XLEN-1:0]    w_quot;
    logic [XLEN-1:0]    w_rem;
    logic               w_div_last;
    logic [XLEN-1:0]    w_q_fix;
    logic [XLEN-1:0]    w_r_fix;

    logic               w_done;
    logic               w_stall;
    logic [XLEN-1:0]    w_rdata;

    assign w_accept     = (r_state == S_IDLE) && mdu_valid && !flush;
    assign w_accept_mul = w_accept && ((mdu_funct == F_MULT) || (mdu_funct == F_MULTU));
    assign w_accept_div = w_accept && ((mdu_funct == F_DIV)  || (mdu_funct == F_DIVU));
    assign w_op_signed  = (mdu_funct == F_MULT) || (mdu_funct == F_DIV);

    // Product is formed from the live operands at accept, then carried down a plain
    // register chain so synthesis can retime the multiplier across the stages.
    assign w_ext_a = {{XLEN{w_op_signed & mdu_a[XLEN-1]}}, mdu_a};
    assign w_ext_b = {{XLEN{w_op_signed & mdu_b[XLEN-1]}}, mdu_b};
    assign w_prod  = w_ext_a * w_ext_b;

    genvar gi;
    generate
        for (gi = 0; gi < MUL_LAT; gi++) begin : g_pipe
            logic [2*XLEN-1:0] r_stage;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (w_accept_mul) begin
                        r_stage <= w_prod;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    r_stage <= g_pipe[gi-1].r_stage;
                end
            end
        end
    endgenerate

    assign w_prod_out = g_pipe[MUL_LAT-1].r_stage;

    assign w_div_dividend = neg_if(mdu_a, w_op_signed & mdu_a[XLEN-1]);
    assign w_div_divisor  = neg_if(mdu_b, w_op_signed & mdu_b[XLEN-1]);

    div_iter u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (w_accept_div),
        .abort    (flush),
        .dividend (w_div_dividend),
        .divisor  (w_div_divisor),
        .quot     (w_quot),
        .rem      (w_rem),
        .last     (w_div_last)
    );

    // Remainder follows the dividend's sign; the overflow case falls out of the magnitudes.
    assign w_q_fix = neg_if(w_quot, r_signed & (r_a[XLEN-1] ^ r_b[XLEN-1]));
    assign w_r_fix = neg_if(w_rem,  r_signed & r_a[XLEN-1]);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        w_done       = 1'b0;
        w_stall      = mdu_valid && is_mdu_funct(mdu_funct) && (r_state != S_IDLE);
        w_rdata      = '0;

        if (mdu_valid && (mdu_funct == F_MFHI)) begin
            w_rdata = r_hi;
        end else if (mdu_valid && (mdu_funct == F_MFLO)) begin
            w_rdata = r_lo;
        end

        case (r_state)
            S_IDLE: begin
                if (mdu_valid && !flush) begin
                    case (mdu_funct)
                        F_MULT, F_MULTU: begin
                            w_state_next = S_MUL;
                            w_cnt_next   = CNT_W'(MUL_LAT - 1);
                        end
                        F_DIV, F_DIVU: begin
                            w_state_next = S_DIV;
                            w_cnt_next   = CNT_W'(DIV_STEPS - 1);
                        end
                        F_MTHI:  w_hi_next = mdu_a;
                        F_MTLO:  w_lo_next = mdu_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == '0) begin
                    w_hi_next    = w_prod_out[2*XLEN-1:XLEN];
                    w_lo_next    = w_prod_out[XLEN-1:0];
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (w_div_last) begin
                    w_state_next = S_FIX;
                    w_cnt_next   = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_FIX: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                if (!flush) begin
                    if (r_b == '0) begin
                        w_lo_next = '1;
                        w_hi_next = r_a;
                    end else begin
                        w_lo_next = w_q_fix;
                        w_hi_next = w_r_fix;
                    end
                    w_done = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            if (w_accept) begin
                r_a      <= mdu_a;
                r_b      <= mdu_b;
                r_signed <= w_op_signed;
            end
        end
    end

    assign mdu_stall = w_stall;
    assign mdu_rdata = w_rdata;
    assign mdu_done  = w_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
